parity_frame_checker: RTL and testbench



---
 rtl/parity_frame_checker.sv | 70 +++++++
 tb/tb_parity_frame_checker.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// Framed serial parity checker: running parity over din_valid-gated bits, frame check on the last bit, saturating error count.
// Frame result visible one cycle after the last bit is accepted; bits presented during the DONE cycle are accepted, so frames can run back to back.
module parity_frame_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W = 8,
    localparam int IDX_W = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             odd_mode,
    input  logic             clear_cnt,
    output logic             detected,
    output logic             frame_done,
    output logic             parity_err,
    output logic [CNT_W-1:0] err_count,
    output logic [IDX_W-1:0] bit_idx
);

    typedef enum logic [1:0] {
        S_EVEN     = 2'b00,
        S_ODD      = 2'b01,
        S_DONE_OK  = 2'b10,
        S_DONE_ERR = 2'b11
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t state;
    logic   cur_par;
    logic   last_bit;
    logic   frame_ok;

    // DONE states carry zero parity so a bit arriving in the DONE cycle starts a fresh frame.
    assign cur_par  = (state == S_ODD);
    assign last_bit = (bit_idx == LAST_IDX);
    assign frame_ok = ((cur_par ^ din) == odd_mode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_EVEN;
            bit_idx   <= '0;
            err_count <= '0;
        end else begin
            if (din_valid) begin
                if (last_bit) begin
                    bit_idx <= '0;
                    state   <= frame_ok ? S_DONE_OK : S_DONE_ERR;
                end else begin
                    bit_idx <= bit_idx + IDX_W'(1);
                    state   <= (cur_par ^ din) ? S_ODD : S_EVEN;
                end
            end else if (state == S_DONE_OK || state == S_DONE_ERR) begin
                state <= S_EVEN;
            end

            if (clear_cnt) begin
                err_count <= '0;
            end else if (din_valid && last_bit && !frame_ok && err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

    assign detected   = (state == S_ODD);
    assign frame_done = (state == S_DONE_OK) || (state == S_DONE_ERR);
    assign parity_err = (state == S_DONE_ERR);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker: default instance plus a CNT_W=2 instance for saturation.
module tb_parity_frame_checker;

    logic clk = 1'b0;
    logic reset;
    logic din;
    logic din_valid;
    logic odd_mode;
    logic clear_cnt;

    logic       detected, frame_done, parity_err;
    logic [7:0] err_count;
    logic [2:0] bit_idx;
    logic       detected2, frame_done2, parity_err2;
    logic [1:0] err_count2;
    logic [2:0] bit_idx2;

    int checks = 0;
    int errors = 0;

    logic frame_a [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic det_a   [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic frame_b [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic det_b   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    always #5 clk = ~clk;

    parity_frame_checker dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .odd_mode(odd_mode), .clear_cnt(clear_cnt), .detected(detected),
        .frame_done(frame_done), .parity_err(parity_err),
        .err_count(err_count), .bit_idx(bit_idx)
    );

    parity_frame_checker #(.FRAME_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .odd_mode(odd_mode), .clear_cnt(clear_cnt), .detected(detected2),
        .frame_done(frame_done2), .parity_err(parity_err2),
        .err_count(err_count2), .bit_idx(bit_idx2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        din_valid = 1'b0;
        din = 1'b0;
        clear_cnt = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; din = 1'b0; din_valid = 1'b0; odd_mode = 1'b0; clear_cnt = 1'b0;
        #12;
        reset = 1'b0;
        #1;
        checks++;
        if ({detected, frame_done, parity_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b required 000", {detected, frame_done, parity_err});
        end
        checks++;
        if (err_count !== 8'd0 || bit_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_cnt_idx got cnt=%0d idx=%0d required 0/0", err_count, bit_idx);
        end
        din_valid = 1'b1;
        din = 1'b1; step();
        din = 1'b0; step();
        din = 1'b0; step();
        din_valid = 1'b0;
        checks++;
        if (bit_idx !== 3'd3 || detected !== 1'b1) begin
            errors++;
            $display("FAIL pre_midreset got idx=%0d det=%b required 3/1", bit_idx, detected);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bit_idx !== 3'd0 || detected !== 1'b0 || frame_done !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL midframe_reset got idx=%0d det=%b done=%b cnt=%0d required 0/0/0/0",
                     bit_idx, detected, frame_done, err_count);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_frame_ok();
        odd_mode = 1'b0;
        din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = frame_a[i];
            step();
            if (i < 7) begin
                checks++;
                if (detected !== det_a[i] || bit_idx !== 3'(i + 1) || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL ok_bit%0d got det=%b idx=%0d done=%b required %b/%0d/0",
                             i, detected, bit_idx, frame_done, det_a[i], i + 1);
                end
            end
        end
        din_valid = 1'b0;
        checks++;
        if ({frame_done, parity_err, detected} !== 3'b100 || bit_idx !== 3'd0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL ok_done got done/err/det=%b idx=%0d cnt=%0d required 100/0/0",
                     {frame_done, parity_err, detected}, bit_idx, err_count);
        end
        step();
        checks++;
        if (frame_done !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL ok_after got done=%b cnt=%0d required 0/0", frame_done, err_count);
        end
    endtask

    task automatic test_frame_err();
        din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = frame_a[i];
            odd_mode = (i == 7) ? 1'b1 : 1'(i % 2);
            step();
        end
        din_valid = 1'b0;
        odd_mode = 1'b0;
        checks++;
        if ({frame_done, parity_err, detected} !== 3'b110 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL err_done got done/err/det=%b cnt=%0d required 110/1",
                     {frame_done, parity_err, detected}, err_count);
        end
        step();
        checks++;
        if (frame_done !== 1'b0 || parity_err !== 1'b0 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL err_pulse_len got done=%b err=%b cnt=%0d required 0/0/1",
                     frame_done, parity_err, err_count);
        end
    endtask

    task automatic test_valid_gaps();
        odd_mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din = frame_a[i];
            din_valid = 1'b1;
            step();
            if (i < 7) begin
                din = ~frame_a[i];
                din_valid = 1'b0;
                step();
                checks++;
                if (detected !== det_a[i] || bit_idx !== 3'(i + 1) || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_hold%0d got det=%b idx=%0d done=%b required %b/%0d/0",
                             i, detected, bit_idx, frame_done, det_a[i], i + 1);
                end
            end
        end
        din_valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || parity_err !== 1'b0 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL gap_done got done=%b err=%b cnt=%0d required 1/0/1",
                     frame_done, parity_err, err_count);
        end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        odd_mode = 1'b1;
        din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = frame_a[i];
            step();
        end
        checks++;
        if (frame_done !== 1'b1 || parity_err !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL b2b_f1 got done=%b err=%b cnt=%0d required 1/1/1",
                     frame_done, parity_err, err_count);
        end
        for (int i = 0; i < 8; i++) begin
            din = frame_b[i];
            step();
            if (i < 7) begin
                checks++;
                if (detected !== det_b[i] || bit_idx !== 3'(i + 1) || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_bit%0d got det=%b idx=%0d done=%b required %b/%0d/0",
                             i, detected, bit_idx, frame_done, det_b[i], i + 1);
                end
            end
        end
        din_valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || parity_err !== 1'b1 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL b2b_f2 got done=%b err=%b cnt=%0d required 1/1/2",
                     frame_done, parity_err, err_count);
        end
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        odd_mode = 1'b1;
        for (int f = 0; f < 5; f++) begin
            din_valid = 1'b1;
            for (int i = 0; i < 8; i++) begin
                din = frame_a[i];
                step();
            end
            din_valid = 1'b0;
            checks++;
            if (err_count2 !== sat_exp[f] || parity_err2 !== 1'b1 || err_count !== 8'(f + 1)) begin
                errors++;
                $display("FAIL sat_f%0d got cnt2=%0d err2=%b cnt=%0d required %0d/1/%0d",
                         f, err_count2, parity_err2, err_count, sat_exp[f], f + 1);
            end
            step();
        end
        din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = frame_a[i];
            clear_cnt = (i == 7);
            step();
        end
        din_valid = 1'b0;
        clear_cnt = 1'b0;
        checks++;
        if (err_count2 !== 2'd0 || err_count !== 8'd0 || parity_err2 !== 1'b1) begin
            errors++;
            $display("FAIL clear_wins got cnt2=%0d cnt=%0d err2=%b required 0/0/1",
                     err_count2, err_count, parity_err2);
        end
        step();
        checks++;
        if (err_count2 !== 2'd0 || frame_done2 !== 1'b0 || detected2 !== 1'b0 || bit_idx2 !== 3'd0) begin
            errors++;
            $display("FAIL clear_hold got cnt2=%0d done2=%b det2=%b idx2=%0d required 0/0/0/0",
                     err_count2, frame_done2, detected2, bit_idx2);
        end
    endtask

    initial begin
        test_reset();
        test_frame_ok();
        test_frame_err();
        test_valid_gaps();
        test_back_to_back();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
